voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphonic voice scheduler that sits between the keyboard/event front end and a bank of NUM_VOICES note datapaths, each holding one frequency register and one wave generator. It accepts note-on and note-off events and assigns each note-on to one voice. Assignment order is: retrigger a voice already holding the same note, else the lowest free voice, else steal the oldest voice. It drives a one-hot load strobe plus a broadcast note/octave bus, and tracks which voices are sounding.

Parameters:
NUM_VOICES, 4, number of voice datapaths managed (2..8)
AGE_W, 8, width of per-voice age counters (saturating)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
note_in  in  1  note-on event strobe, sampled only when ev_ready=1
note_off  in  1  note-off event strobe, sampled only when ev_ready=1
note  in  4  note index (0..11) of the event
octave  in  3  octave of the event
ev_ready  out  1  block can accept an event this cycle
voice_ld  out  NUM_VOICES  one-hot load strobe to target voice, one cycle
voice_note  out  4  registered note for the voice being loaded
voice_octave  out  3  registered octave for the voice being loaded
voice_active  out  NUM_VOICES  bit v=1 while voice v is sounding
steal  out  1  one-cycle pulse coincident with voice_ld when an active voice was stolen

Behaviour:
- Reset (asynchronous, reset=0): FSM to IDLE, ev_ready=1, voice_ld=0, voice_note=0, voice_octave=0, voice_active=0, steal=0, all stored note/octave/age registers cleared. Reset asserted mid-sequence aborts the event immediately; no voice_ld is issued afterwards.
- Per-voice state: held note (4b), held octave (3b), age (AGE_W, saturating at all-ones), active bit.
- FSM states:
  - IDLE: ev_ready=1. At a clock edge with note_off=1 -> REL. Else with note_in=1 -> SCAN. Event note/octave are latched in both cases.
  - SCAN: one cycle, picks the target voice, then -> LOAD.
  - LOAD: voice_ld[target]=1 for exactly one cycle with voice_note/voice_octave valid; -> IDLE.
  - REL: one cycle; -> IDLE.
  - ev_ready=0 in every state except IDLE.
- Simultaneous note_in and note_off: note_off wins; the note_in is dropped (not queued).
- Note-on latency: event edge t -> SCAN in cycle t+1 -> voice_ld high in cycle t+2 -> ev_ready high again in cycle t+3.
- Note-off latency: event edge t -> REL in cycle t+1 -> ev_ready high again in cycle t+2.
- Target selection in SCAN, strict priority:
  1. Active voice whose held note and octave both equal the event: retrigger. If several match, take the lowest index.
  2. Lowest-index voice with active=0.
  3. Steal the active voice with the largest age; ties go to the lowest index. steal=1 during LOAD.
- Updates at the LOAD edge:
  - Target: active=1, age=0, held note/octave = event values.
  - Every other active voice: age+1, saturating at all-ones.
  - Inactive voices: age unchanged.
- REL: the lowest-index active voice matching the event note and octave gets active=0; its age and held values are unchanged. No match -> no-op, no error.
- voice_active updates registered, visible the cycle after LOAD or REL.
- No output is driven combinationally from inputs.

Test Plan:
1. Reset, then note_in (note=9, oct=4) at edge t -> voice_ld=4'b0001 in cycle t+2, voice_note=9, voice_octave=4, steal=0; voice_active=0001 in cycle t+3; ev_ready low in t+1..t+2.
2. Four distinct note-ons (notes 0,2,4,5; oct 3) -> voice_ld sequence 0001, 0010, 0100, 1000; voice_active=1111.
3. From test 2, note_in (note=7, oct=3) -> voice_ld=0001 with steal=1, since voice0 has age 3. A further note_in (note=9, oct=3) -> voice_ld=0010 with steal=1.
4. From test 2, note_in (note=2, oct=3) -> retrigger: voice_ld=0010, steal=0, voice_active stays 1111, voice1 age becomes 0.
5. From test 2, note_off (note=4, oct=3) -> voice_active=1011 two cycles later. A following note_in (note=11, oct=5) -> voice_ld=0100, steal=0. note_off for an unheld note (note=1, oct=1) -> voice_active unchanged.
6. note_in and note_off both high (note=0, oct=3, held by voice0) -> only the release occurs, voice_ld never asserts. Separately, reset asserted during SCAN -> all outputs 0 immediately and no voice_ld after reset release.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on events to voices (retrigger, lowest free, oldest steal) and tracks sounding voices.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  note_in_i,
  input  logic                  note_off_i,
  input  logic [3:0]            note_i,
  input  logic [2:0]            octave_i,
  output logic                  ev_ready_o,
  output logic [NUM_VOICES-1:0] voice_ld_o,
  output logic [3:0]            voice_note_o,
  output logic [2:0]            voice_octave_o,
  output logic [NUM_VOICES-1:0] voice_active_o,
  output logic                  steal_o
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, LOAD, REL} state_t;
  state_t state_q, state_d;
  logic [3:0] ev_note_q;
  logic [2:0] ev_oct_q;
  logic [NUM_VOICES-1:0][3:0] hnote_q;
  logic [NUM_VOICES-1:0][2:0] hoct_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;
  logic [NUM_VOICES-1:0] active_q;
  logic [IW-1:0] tgt_q, tgt_d, match_idx, free_idx, old_idx;
  logic steal_q, steal_d, match_f, free_f;
  logic [AGE_W-1:0] old_age;
  // The matcher also serves REL, since the latched event is what both compare against.
  always_comb begin
    match_f = 1'b0;
    match_idx = '0;
    free_f = 1'b0;
    free_idx = '0;
    old_idx = '0;
    old_age = age_q[0];
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && hnote_q[v] == ev_note_q && hoct_q[v] == ev_oct_q) begin
        match_f = 1'b1;
        match_idx = IW'(v);
      end
      if (!active_q[v]) begin
        free_f = 1'b1;
        free_idx = IW'(v);
      end
    end
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (active_q[v] && age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = IW'(v);
      end
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (note_off_i ? REL : note_in_i ? SCAN : IDLE)
            : state_q == SCAN ? LOAD : IDLE;
    tgt_d = match_f ? match_idx : free_f ? free_idx : old_idx;
    steal_d = !match_f && !free_f;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      ev_note_q <= '0;
      ev_oct_q <= '0;
      hnote_q <= '0;
      hoct_q <= '0;
      age_q <= '0;
      active_q <= '0;
      tgt_q <= '0;
      steal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (note_in_i || note_off_i)) begin
        ev_note_q <= note_i;
        ev_oct_q <= octave_i;
      end
      if (state_q == SCAN) begin
        tgt_q <= tgt_d;
        steal_q <= steal_d;
      end
      if (state_q == LOAD) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (IW'(v) == tgt_q) begin
            active_q[v] <= 1'b1;
            age_q[v] <= '0;
            hnote_q[v] <= ev_note_q;
            hoct_q[v] <= ev_oct_q;
          end else if (active_q[v] && age_q[v] != '1) begin
            age_q[v] <= age_q[v] + AGE_W'(1);
          end
        end
      end
      if (state_q == REL && match_f) active_q[match_idx] <= 1'b0;
    end
  end
  assign ev_ready_o = state_q == IDLE;
  assign voice_ld_o = state_q == LOAD ? NUM_VOICES'(1) << tgt_q : '0;
  assign steal_o = state_q == LOAD && steal_q;
  assign voice_note_o = ev_note_q;
  assign voice_octave_o = ev_oct_q;
  assign voice_active_o = active_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scoreboard bench for voice_allocator.
module tb_voice_allocator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, note_in, note_off, ev_ready, steal;
  logic [3:0] note, voice_ld, voice_note, voice_active;
  logic [2:0] oct, voice_oct;
  typedef struct packed {
    logic [3:0] ld;
    logic [3:0] n;
    logic [2:0] o;
    logic       st;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  voice_allocator #(.NUM_VOICES(4), .AGE_W(8)) dut (
    .clk_i(clk), .reset_ni(rst_n), .note_in_i(note_in), .note_off_i(note_off),
    .note_i(note), .octave_i(oct), .ev_ready_o(ev_ready), .voice_ld_o(voice_ld),
    .voice_note_o(voice_note), .voice_octave_o(voice_oct),
    .voice_active_o(voice_active), .steal_o(steal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    note_in = 1'b0;
    note_off = 1'b0;
    note = '0;
    oct = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic on(input logic [3:0] n, input logic [2:0] o, input logic [3:0] ld,
                    input logic st, input string tag);
    exp_t e;
    int c;
    sb.push_back(exp_t'{ld, n, o, st});
    note = n;
    oct = o;
    note_in = 1'b1;
    step();
    note_in = 1'b0;
    chk({tag, "_busy_scan"}, 32'(ev_ready), 0);
    c = 0;
    do begin
      step();
      c++;
    end while (voice_ld == 0 && c < 6);
    chk({tag, "_latency"}, c, 1);
    if (voice_ld != 0) begin
      e = sb.pop_front();
      chk({tag, "_ld"}, 32'(voice_ld), 32'(e.ld));
      chk({tag, "_note"}, 32'(voice_note), 32'(e.n));
      chk({tag, "_oct"}, 32'(voice_oct), 32'(e.o));
      chk({tag, "_steal"}, 32'(steal), 32'(e.st));
      chk({tag, "_busy_load"}, 32'(ev_ready), 0);
    end
    step();
    chk({tag, "_ready"}, 32'(ev_ready), 1);
    chk({tag, "_ld_one_cycle"}, 32'(voice_ld), 0);
  endtask

  task automatic off(input logic [3:0] n, input logic [2:0] o, input string tag);
    note = n;
    oct = o;
    note_off = 1'b1;
    step();
    note_off = 1'b0;
    chk({tag, "_busy"}, 32'(ev_ready), 0);
    step();
    chk({tag, "_ready"}, 32'(ev_ready), 1);
  endtask

  task automatic fill4();
    do_reset();
    on(4'd0, 3'd3, 4'b0001, 1'b0, "fill0");
    on(4'd2, 3'd3, 4'b0010, 1'b0, "fill1");
    on(4'd4, 3'd3, 4'b0100, 1'b0, "fill2");
    on(4'd5, 3'd3, 4'b1000, 1'b0, "fill3");
    chk("fill_active", 32'(voice_active), 32'hf);
  endtask

  initial begin
    logic ld_any;
    do_reset();
    chk("rst_ready", 32'(ev_ready), 1);
    chk("rst_outs", {voice_ld, voice_note, voice_oct, voice_active, steal}, 0);
    on(4'd9, 3'd4, 4'b0001, 1'b0, "t1");
    chk("t1_active", 32'(voice_active), 32'h1);

    fill4();
    on(4'd7, 3'd3, 4'b0001, 1'b1, "t3_steal0");
    on(4'd9, 3'd3, 4'b0010, 1'b1, "t3_steal1");
    chk("t3_active", 32'(voice_active), 32'hf);

    fill4();
    on(4'd2, 3'd3, 4'b0010, 1'b0, "t4_retrig");
    chk("t4_active", 32'(voice_active), 32'hf);
    // voice1 was retriggered (age 0), voice0 now oldest at 4, voice3 youngest non-target
    on(4'd8, 3'd3, 4'b0001, 1'b1, "t4_steal");
    on(4'd10, 3'd3, 4'b0100, 1'b1, "t4_steal2");

    fill4();
    off(4'd4, 3'd3, "t5_off");
    chk("t5_active_rel", 32'(voice_active), 32'hb);
    on(4'd11, 3'd5, 4'b0100, 1'b0, "t5_refill");
    chk("t5_active_refill", 32'(voice_active), 32'hf);
    off(4'd1, 3'd1, "t5_off_none");
    chk("t5_active_unchanged", 32'(voice_active), 32'hf);

    fill4();
    note = 4'd0;
    oct = 3'd3;
    note_in = 1'b1;
    note_off = 1'b1;
    step();
    note_in = 1'b0;
    note_off = 1'b0;
    ld_any = 1'b0;
    repeat (4) begin
      ld_any |= |voice_ld;
      step();
    end
    chk("t6_both_no_ld", 32'(ld_any), 0);
    chk("t6_both_active", 32'(voice_active), 32'he);

    note = 4'd3;
    oct = 3'd2;
    note_in = 1'b1;
    step();
    note_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {voice_ld, voice_note, voice_oct, voice_active, steal}, 0);
    chk("t6_rst_ready", 32'(ev_ready), 1);
    #3 rst_n = 1'b1;
    ld_any = 1'b0;
    repeat (5) begin
      step();
      ld_any |= |voice_ld;
    end
    chk("t6_rst_no_ld", 32'(ld_any), 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
